maze_tile_writer: RTL and testbench
===================================

MAZE_TILE_WRITER -- requirements
Module: maze_tile_writer

Interface
REQ-001 Parameter SCREEN_WIDTH, 270, frame-buffer row pitch and width in pixels.
REQ-002 Parameter SCREEN_HEIGHT, 270, frame height in pixels.
REQ-003 Parameter CELL_SIZE, 30, cell edge length in pixels.
REQ-004 Parameter GRID_DIM, 9, cells per row and column (GRID_DIM*CELL_SIZE = SCREEN_WIDTH).
REQ-005 Parameter BG_COLOR, 4'h0, colour written by a clear.
REQ-006 Parameter LINE_COLOR, 4'hF, grid-line colour (Configuration only).
REQ-007 clk  in  1  single clock; same clock as the frame-buffer write port.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 cell_valid  in  1  cell-update request.
REQ-010 cell_ready  out  1  request accepted on a clk edge where cell_valid and cell_ready are both high.
REQ-011 cell_x, cell_y  in  4 each  grid coordinates of the cell.
REQ-012 cell_color  in  4  fill colour for the cell.
REQ-013 clear_req  in  1  one-cycle request to clear the whole frame.
REQ-014 w_addr  out  17  frame-buffer write address.
REQ-015 w_en  out  1  frame-buffer write enable.
REQ-016 pixel_data  out  4  frame-buffer write data.
REQ-017 busy  out  1  high while CLEAR or DRAW is active.
REQ-018 done  out  1  one-cycle pulse after the final write of a clear or draw.
REQ-019 err  out  1  one-cycle pulse when an out-of-range request is accepted.

Function
REQ-020 The block SHALL implement FSM states IDLE, CLEAR, DRAW.
REQ-021 w_addr, w_en, pixel_data, done, err SHALL be registered outputs.
REQ-022 cell_ready SHALL be combinational: high only in IDLE with clear_req low.
REQ-023 In IDLE, clear_req SHALL take priority over cell_valid; a simultaneous cell request is not accepted.
REQ-024 CLEAR SHALL write BG_COLOR to addresses 0..SCREEN_WIDTH*SCREEN_HEIGHT-1 (0..72899) in ascending order, one write per cycle, then return to IDLE.
REQ-025 On acceptance, cell_x, cell_y, cell_color SHALL be captured; later input changes have no effect.
REQ-026 DRAW SHALL write CELL_SIZE*CELL_SIZE pixels in raster order (row-major, left to right), one per cycle, w_en high on every cycle of the run.
REQ-027 Base address SHALL be (cell_y*CELL_SIZE)*SCREEN_WIDTH + cell_x*CELL_SIZE; successive addresses increment by 1 and by SCREEN_WIDTH-CELL_SIZE+1 at each row end, without a per-pixel multiplier.
REQ-028 Arithmetic SHALL be at least 17 bits wide; the largest address (72899) SHALL never wrap.
REQ-029 Latency: a request or clear accepted at edge N SHALL produce its first w_en at the output after edge N+1; done SHALL pulse on the cycle after the last w_en.
REQ-030 A request with cell_x >= GRID_DIM or cell_y >= GRID_DIM SHALL be accepted, produce no writes, pulse err one cycle later, stay in IDLE, and not pulse done.
REQ-031 Inputs received while busy SHALL be ignored (cell_ready low; clear_req dropped).
REQ-032 w_en SHALL be low in IDLE; w_addr and pixel_data SHALL hold their last values.

Reset
REQ-033 Reset SHALL force IDLE, w_en=0, w_addr=0, pixel_data=0, done=0, err=0, busy=0, aborting any write run immediately.
REQ-034 On the first clk edge after reset deasserts, the block SHALL enter CLEAR automatically.
REQ-035 A reset during DRAW or CLEAR SHALL not resume the aborted run; only the automatic clear SHALL follow.

Configuration
REQ-036 With macro MAZE_GRID_LINES_EN defined, DRAW SHALL write LINE_COLOR instead of cell_color for pixels at local row 0 or local column 0 of the cell; write count and timing SHALL be unchanged.
REQ-037 Without MAZE_GRID_LINES_EN, every DRAW pixel SHALL be cell_color.

Verification
REQ-038 Release reset -> busy high, 72900 writes at addresses 0..72899, data 4'h0, one done pulse, then cell_ready high.
REQ-039 After idle, request (x=2, y=1, color=4'hA) -> 900 writes; first address 8160, then 8161..8189, 8430 (start of row 2); last address 16019; done pulse one cycle after last write.
REQ-040 Request (x=9, y=0) -> no w_en, err pulse one cycle after acceptance, cell_ready high again next cycle.
REQ-041 clear_req and cell_valid high together in IDLE -> CLEAR runs; cell not accepted; cell_ready low throughout the clear.
REQ-042 Reset asserted at write 400 of a DRAW -> w_en low immediately; after release, full 72900-write clear; no further writes to the aborted cell.
REQ-043 With MAZE_GRID_LINES_EN, request (x=0, y=0, color=4'h3) -> address 0..29 and every 270*k (k=1..29) carry 4'hF; address 271 carries 4'h3.

Source files
------------

// File: rtl/maze_tile_writer_if.sv
// Cell-request and frame-buffer write bundle for maze_tile_writer.
// master drives cell/clear requests; slave (the writer) drives the frame-buffer port and status.
interface maze_tile_writer_if;
  logic        cell_valid;
  logic        cell_ready;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [3:0]  cell_color;
  logic        clear_req;
  logic [16:0] w_addr;
  logic        w_en;
  logic [3:0]  pixel_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output cell_valid, cell_x, cell_y, cell_color, clear_req,
    input  cell_ready, w_addr, w_en, pixel_data, busy, done, err
  );

  modport slave (
    input  cell_valid, cell_x, cell_y, cell_color, clear_req,
    output cell_ready, w_addr, w_en, pixel_data, busy, done, err
  );
endinterface

// File: rtl/maze_tile_writer.sv
// Frame-buffer writer: full-frame clear and per-cell fill, one pixel per clock.
// Optional MAZE_GRID_LINES_EN paints each cell's top row and left column with LINE_COLOR.
module maze_tile_writer #(
  parameter int unsigned SCREEN_WIDTH  = 270,
  parameter int unsigned SCREEN_HEIGHT = 270,
  parameter int unsigned CELL_SIZE     = 30,
  parameter int unsigned GRID_DIM      = 9,
  parameter logic [3:0]  BG_COLOR      = 4'h0
`ifdef MAZE_GRID_LINES_EN
  ,
  parameter logic [3:0]  LINE_COLOR    = 4'hF
`endif
) (
  input logic               clk,
  input logic               reset,
  maze_tile_writer_if.slave bus
);

  localparam int unsigned    NUM_PIX   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int unsigned    CW        = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam logic [16:0]    LAST_ADDR = 17'(NUM_PIX - 1);
  localparam logic [16:0]    ROW_STEP  = 17'(SCREEN_WIDTH - CELL_SIZE + 1);
  localparam logic [CW-1:0]  CELL_LAST = CW'(CELL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pend_clear, w_pend_clear_nxt;
  logic [16:0]   r_addr, w_addr_nxt;
  logic [CW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [3:0]    r_color, w_color_nxt;
  logic [16:0]   r_w_addr, w_w_addr_nxt;
  logic          r_w_en, w_w_en_nxt;
  logic [3:0]    r_pix, w_pix_nxt;
  logic          r_last, w_last_nxt;
  logic          r_err_pend, w_err_pend_nxt;
  logic          r_done;
  logic          r_err;

  logic          w_oor;
  logic [16:0]   w_base;
  logic [3:0]    w_cell_pix;

  // Only multiply is at acceptance; the draw walks addresses incrementally.
  assign w_base = 17'(32'(bus.cell_y) * (CELL_SIZE * SCREEN_WIDTH) + 32'(bus.cell_x) * CELL_SIZE);
  assign w_oor  = (32'(bus.cell_x) >= GRID_DIM) || (32'(bus.cell_y) >= GRID_DIM);

`ifdef MAZE_GRID_LINES_EN
  assign w_cell_pix = ((r_row == '0) || (r_col == '0)) ? LINE_COLOR : r_color;
`else
  assign w_cell_pix = r_color;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_pend_clear_nxt = r_pend_clear;
    w_addr_nxt       = r_addr;
    w_row_nxt        = r_row;
    w_col_nxt        = r_col;
    w_color_nxt      = r_color;
    w_w_addr_nxt     = r_w_addr;
    w_w_en_nxt       = 1'b0;
    w_pix_nxt        = r_pix;
    w_last_nxt       = 1'b0;
    w_err_pend_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Post-reset clear and clear_req both outrank a pending cell request.
        if (r_pend_clear || bus.clear_req) begin
          w_state_nxt      = CLEAR;
          w_pend_clear_nxt = 1'b0;
          w_addr_nxt       = '0;
        end else if (bus.cell_valid) begin
          if (w_oor) begin
            w_err_pend_nxt = 1'b1;
          end else begin
            w_state_nxt = DRAW;
            w_addr_nxt  = w_base;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_color_nxt = bus.cell_color;
          end
        end
      end
      CLEAR: begin
        w_w_en_nxt   = 1'b1;
        w_w_addr_nxt = r_addr;
        w_pix_nxt    = BG_COLOR;
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b1;
        end else begin
          w_addr_nxt = r_addr + 17'd1;
        end
      end
      DRAW: begin
        w_w_en_nxt   = 1'b1;
        w_w_addr_nxt = r_addr;
        w_pix_nxt    = w_cell_pix;
        if (r_col == CELL_LAST) begin
          w_col_nxt  = '0;
          w_row_nxt  = r_row + CW'(1);
          w_addr_nxt = r_addr + ROW_STEP;
          if (r_row == CELL_LAST) begin
            w_state_nxt = IDLE;
            w_last_nxt  = 1'b1;
          end
        end else begin
          w_col_nxt  = r_col + CW'(1);
          w_addr_nxt = r_addr + 17'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pend_clear <= 1'b1;
      r_addr       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_color      <= '0;
      r_w_addr     <= '0;
      r_w_en       <= 1'b0;
      r_pix        <= '0;
      r_last       <= 1'b0;
      r_err_pend   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_clear <= w_pend_clear_nxt;
      r_addr       <= w_addr_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_color      <= w_color_nxt;
      r_w_addr     <= w_w_addr_nxt;
      r_w_en       <= w_w_en_nxt;
      r_pix        <= w_pix_nxt;
      r_last       <= w_last_nxt;
      r_err_pend   <= w_err_pend_nxt;
      r_done       <= r_last;
      r_err        <= r_err_pend;
    end
  end

  assign bus.cell_ready = (r_state == IDLE) && !bus.clear_req && !r_pend_clear;
  assign bus.busy       = (r_state != IDLE);
  assign bus.w_addr     = r_w_addr;
  assign bus.w_en       = r_w_en;
  assign bus.pixel_data = r_pix;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_maze_tile_writer.sv
// Self-checking bench for maze_tile_writer: directed table, random cell requests against a
// frame-geometry model, and reset-abort / priority sequences.
module tb_maze_tile_writer;
  localparam int W = 270;
  localparam int H = 270;
  localparam int C = 30;
  localparam int G = 9;
  localparam logic [3:0] BG   = 4'h0;
  localparam logic [3:0] LINE = 4'hF;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  maze_tile_writer_if bus ();

  maze_tile_writer #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .CELL_SIZE    (C),
    .GRID_DIM     (G),
    .BG_COLOR     (BG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/event log sampled mid-cycle.
  int          wq_addr[$];
  logic [3:0]  wq_data[$];
  int          wq_cyc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          ready_busy_viol = 0;

  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      wq_addr.push_back(int'(bus.w_addr));
      wq_data.push_back(bus.pixel_data);
      wq_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.err === 1'b1) err_cyc.push_back(cyc);
    if (bus.busy === 1'b1 && bus.cell_ready === 1'b1) ready_busy_viol++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  int         exp_addr[$];
  logic [3:0] exp_data[$];

  // Reference: cell covers rows y*C..y*C+C-1, columns x*C..x*C+C-1, visited row by row.
  function automatic void model_cell(input int x, input int y, input logic [3:0] c);
    exp_addr.delete();
    exp_data.delete();
    if (x >= G || y >= G) return;
    for (int r = 0; r < C; r++) begin
      for (int k = 0; k < C; k++) begin
        exp_addr.push_back((y * C + r) * W + x * C + k);
`ifdef MAZE_GRID_LINES_EN
        exp_data.push_back((r == 0 || k == 0) ? LINE : c);
`else
        exp_data.push_back(c);
`endif
      end
    end
  endfunction

  function automatic void model_clear(input int n);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(BG);
    end
  endfunction

  function automatic void clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cyc.delete();
    err_cyc.delete();
  endfunction

  task automatic compare_model(input string name);
    int nbad  = 0;
    int first = -1;
    int n     = (wq_addr.size() < exp_addr.size()) ? wq_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (wq_addr[i] != exp_addr[i] || wq_data[i] !== exp_data[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    check({name, " write_count"}, wq_addr.size(), exp_addr.size());
    check($sformatf("%s bad_writes(first idx %0d)", name, first), nbad, 0);
  endtask

  task automatic wait_finish(input int budget, input string name);
    int n = 0;
    while (done_cyc.size() == 0 && err_cyc.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({name, " finish_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic send_cell(input int x, input int y, input logic [3:0] c, output int acc);
    int n = 0;
    @(negedge clk);
    clear_log();
    bus.cell_x     = 4'(x);
    bus.cell_y     = 4'(y);
    bus.cell_color = c;
    bus.cell_valid = 1'b1;
    while (bus.cell_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_wait_timeout", 0, 1);
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic run_cell(input int x, input int y, input logic [3:0] c, input string name);
    int acc;
    bit oor;
    oor = (x >= G) || (y >= G);
    model_cell(x, y, c);
    send_cell(x, y, c, acc);
    @(negedge clk);
    // Scrambled inputs after acceptance must not affect the run.
    bus.cell_valid = 1'b0;
    bus.cell_x     = 4'($urandom_range(0, 15));
    bus.cell_y     = 4'($urandom_range(0, 15));
    bus.cell_color = 4'($urandom_range(0, 15));
    check({name, " ready_after_accept"}, bus.cell_ready, oor ? 1 : 0);
    wait_finish(2000, name);
    compare_model(name);
    if (oor) begin
      check({name, " err_pulses"}, err_cyc.size(), 1);
      check({name, " err_cycle"}, (err_cyc.size() > 0) ? err_cyc[0] : -1, acc + 1);
      check({name, " done_pulses"}, done_cyc.size(), 0);
    end else begin
      check({name, " err_pulses"}, err_cyc.size(), 0);
      check({name, " done_pulses"}, done_cyc.size(), 1);
      check({name, " first_wen_cycle"}, (wq_cyc.size() > 0) ? wq_cyc[0] : -1, acc + 1);
      check({name, " contiguous"}, (wq_cyc.size() > 0) ? wq_cyc[$] - wq_cyc[0] + 1 : -1,
            wq_cyc.size());
      check({name, " done_cycle"}, (done_cyc.size() > 0 && wq_cyc.size() > 0) ?
            done_cyc[0] - wq_cyc[$] : -1, 1);
    end
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [3:0] c;
    int         cnt;
    int         first_a;
    int         row1_a;
    int         last_a;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int rel;

    tbl[0] = '{x: 2, y: 1, c: 4'hA, cnt: 900, first_a: 8160,  row1_a: 8430,  last_a: 16019};
    tbl[1] = '{x: 9, y: 0, c: 4'h7, cnt: 0,   first_a: 0,     row1_a: 0,     last_a: 0};
    tbl[2] = '{x: 8, y: 8, c: 4'h5, cnt: 900, first_a: 65040, row1_a: 65310, last_a: 72899};
    tbl[3] = '{x: 0, y: 9, c: 4'h2, cnt: 0,   first_a: 0,     row1_a: 0,     last_a: 0};
    tbl[4] = '{x: 0, y: 0, c: 4'h3, cnt: 900, first_a: 0,     row1_a: 270,   last_a: 7859};
    tbl[5] = '{x: 15, y: 15, c: 4'hC, cnt: 0, first_a: 0,     row1_a: 0,     last_a: 0};

    reset          = 1'b1;
    bus.cell_valid = 1'b0;
    bus.cell_x     = '0;
    bus.cell_y     = '0;
    bus.cell_color = '0;
    bus.clear_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset w_en", bus.w_en, 0);
    check("reset w_addr", bus.w_addr, 0);
    check("reset pixel_data", bus.pixel_data, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset busy", bus.busy, 0);

    // Automatic clear; a cell request and a clear_req arrive mid-run and must be ignored.
    clear_log();
    model_clear(W * H);
    bus.cell_x     = 4'd1;
    bus.cell_y     = 4'd1;
    bus.cell_color = 4'h9;
    bus.cell_valid = 1'b1;
    reset          = 1'b0;
    @(posedge clk);
    #1 rel = cyc;
    check("clear busy", bus.busy, 1);
    n = 0;
    while (done_cyc.size() == 0 && n < 80000) begin
      @(negedge clk);
      n++;
      if (n == 1000) bus.cell_valid = 1'b0;
      bus.clear_req = (n == 2000);
    end
    if (n >= 80000) check("clear finish_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #1;
    compare_model("clear");
    check("clear first_wen_cycle", (wq_cyc.size() > 0) ? wq_cyc[0] : -1, rel + 1);
    check("clear done_pulses", done_cyc.size(), 1);
    check("clear done_cycle", (done_cyc.size() > 0 && wq_cyc.size() > 0) ?
          done_cyc[0] - wq_cyc[$] : -1, 1);
    check("clear ready_after", bus.cell_ready, 1);
    check("idle busy", bus.busy, 0);

    // clear_req outranks cell_valid combinationally; withdrawn before the edge.
    @(negedge clk);
    bus.clear_req  = 1'b1;
    bus.cell_valid = 1'b1;
    #1 check("prio ready_with_clear_req", bus.cell_ready, 0);
    bus.clear_req = 1'b0;
    #1 check("prio ready_without_clear_req", bus.cell_ready, 1);
    bus.cell_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      run_cell(tbl[i].x, tbl[i].y, tbl[i].c, nm);
      check({nm, " count"}, wq_addr.size(), tbl[i].cnt);
      if (tbl[i].cnt > 0 && wq_addr.size() == tbl[i].cnt) begin
        check({nm, " first_addr"}, wq_addr[0], tbl[i].first_a);
        check({nm, " second_addr"}, wq_addr[1], tbl[i].first_a + 1);
        check({nm, " row1_addr"}, wq_addr[C], tbl[i].row1_a);
        check({nm, " last_addr"}, wq_addr[$], tbl[i].last_a);
      end
    end

    for (int i = 0; i < 6; i++) begin
      int rx;
      int ry;
      logic [3:0] rc;
      rx = int'($urandom_range(0, 10));
      ry = int'($urandom_range(0, 10));
      rc = 4'($urandom_range(0, 15));
      run_cell(rx, ry, rc, $sformatf("rnd%0d(x=%0d,y=%0d)", i, rx, ry));
    end

    // Reset during a draw: abort immediately, then only the automatic clear follows.
    send_cell(3, 4, 4'h6, acc);
    @(negedge clk);
    bus.cell_valid = 1'b0;
    n = 0;
    while (wq_addr.size() < 400 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort reached_400", (wq_addr.size() >= 400) ? 1 : 0, 1);
    #1 reset = 1'b1;
    #1;
    check("abort w_en", bus.w_en, 0);
    check("abort busy", bus.busy, 0);
    check("abort w_addr", bus.w_addr, 0);
    check("abort done", bus.done, 0);
    clear_log();
    repeat (3) @(negedge clk);
    check("abort writes_in_reset", wq_addr.size(), 0);
    reset = 1'b0;
    @(posedge clk);
    #1 rel = cyc;
    repeat (1500) @(negedge clk);
    #1;
    model_clear(1499);
    compare_model("restart_clear");
    check("restart first_wen_cycle", (wq_cyc.size() > 0) ? wq_cyc[0] : -1, rel + 1);
    check("restart busy", bus.busy, 1);
    check("restart ready", bus.cell_ready, 0);
    check("restart done_pulses", done_cyc.size(), 0);
    check("ready_never_with_busy", ready_busy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
